spi_ram_arbiter: RTL and testbench
==================================

Name: spi_ram_arbiter

Overview:
- Sequences and shares one 256x8 synchronous single-port RAM between the SPI slave command stream and a local host port.
- Decodes the 10-bit SPI frames: 2-bit command plus 8-bit payload.
- Holds one pending SPI access and arbitrates it against host requests, round-robin by default.
- Returns read data to the SPI slave on tx_data/tx_valid and to the host on host_rdata/host_rvalid.

Parameters:
- HOST_FIXED_PRIO, 0: 0 = round-robin between SPI and host; 1 = host always wins a simultaneous contest.
- ADDR_SIZE, 8: RAM address width; must equal the SPI payload width (8).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  10  SPI frame; [9:8] command, [7:0] payload
- rx_valid  in  1  one-cycle pulse, rx_data valid
- tx_data  out  8  read data to SPI slave
- tx_valid  out  1  one-cycle pulse, tx_data valid
- spi_ovr  out  1  one-cycle pulse, SPI data command dropped
- host_req  in  1  host request level; fields stable until grant
- host_we  in  1  1 = write, 0 = read
- host_addr  in  8  host address
- host_wdata  in  8  host write data
- host_gnt  out  1  one-cycle pulse, host request accepted
- host_rdata  out  8  host read data
- host_rvalid  out  1  one-cycle pulse, host_rdata valid
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  8  RAM address
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, valid the cycle after a read strobe

Behaviour:
- Reset (async, rst_n=0):
  - All outputs clear to 0.
  - wr_addr_q, rd_addr_q and spi_pend clear to 0.
  - last_winner is set to HOST, so SPI wins the first tie.
  - FSM goes to IDLE. An in-flight access is abandoned; no valid pulse is produced for it.
- SPI decode on rx_valid:
  - Cmd 00: wr_addr_q <= payload. No RAM access.
  - Cmd 10: rd_addr_q <= payload. No RAM access.
  - Cmd 01: latch pending write {addr=wr_addr_q, data=payload} and set spi_pend.
  - Cmd 11: latch pending read {addr=rd_addr_q} and set spi_pend. The payload is ignored.
  - A pending entry keeps its own address copy, so later address commands do not alter it.
- SPI overrun:
  - Trigger: a data command (01/11) arrives while spi_pend=1 and SPI is not granted on that edge.
  - The new command is dropped, the pending entry is kept, and spi_ovr pulses for 1 cycle.
  - If the SPI grant and a new data command coincide, the new command is accepted (set wins over clear).
- FSM states: IDLE, ACCESS, RDATA.
  - IDLE: if spi_pend or host_req, select a winner and go to ACCESS, registering ram_en=1, ram_we, ram_addr, ram_wdata. Otherwise stay in IDLE.
  - Single requester: it wins.
  - Both requesting: the winner is the opposite of last_winner (HOST_FIXED_PRIO=0), or host (HOST_FIXED_PRIO=1).
  - last_winner updates on every grant.
  - ACCESS: ram_en=1 for exactly this cycle. If the winner is host, host_gnt=1 this cycle. If the winner is SPI, spi_pend clears at the entry edge.
  - ACCESS exits: a write returns to IDLE; a read goes to RDATA.
  - RDATA: capture ram_rdata into tx_data (SPI) or host_rdata (host), and pulse the matching valid in the next cycle. Then return to IDLE.
- Outside ACCESS, ram_en=ram_we=0. ram_addr/ram_wdata hold their last values.
- Latency, SPI read: rx_valid in cycle 0; spi_pend in cycle 1; ACCESS in cycle 2; RDATA in cycle 3; tx_valid in cycle 4.
- Latency, host read: host_req in cycle 0 (in IDLE); ACCESS+gnt in cycle 1; RDATA in cycle 2; host_rvalid in cycle 3.
- Latency, writes: a write occupies 2 cycles (IDLE, ACCESS).
- Host fields are sampled only on the IDLE→ACCESS edge. host_req may remain high after gnt to issue the next request; it is re-arbitrated in IDLE.
- tx_data and host_rdata hold their value until the next respective read.

Test Plan:
- SPI write/read: send frames 0x005, 0x1A7, 0x205, 0x300 -> RAM[5]=0xA7 written with ram_we=1 at ram_addr=5; tx_data=0xA7 with tx_valid exactly 4 cycles after the 0x300 rx_valid.
- Host read: host_req=1, we=0, addr=0x10, with RAM[0x10]=0x3C -> host_gnt in cycle 1; host_rvalid with host_rdata=0x3C in cycle 3; no tx_valid.
- Contest: SPI read pending and host_req both high in IDLE after reset -> SPI granted first, host next. Repeat the contest -> host first (round-robin). With HOST_FIXED_PRIO=1 -> host first both times.
- Overrun: two data frames 1 cycle apart while host holds the RAM -> second frame dropped, spi_ovr pulses once, first frame completes unchanged.
- Address isolation: pending write to addr 3, then frame 0x009 before grant -> write lands at address 3; the next write goes to address 9.
- Reset mid-read: assert rst_n=0 during RDATA -> all outputs 0 immediately; no tx_valid/host_rvalid after release; FSM in IDLE.

Source files
------------

// File: rtl/spi_ram_arbiter_if.sv
// Host-side request/grant bundle for spi_ram_arbiter.
// The host raises host_req and holds host_we/addr/wdata stable until host_gnt pulses.
// A read then returns one host_rvalid pulse with host_rdata. The arbiter has no backpressure on the return path.
interface spi_ram_arbiter_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 host_req;
    logic                 host_we;
    logic [ADDR_SIZE-1:0] host_addr;
    logic [7:0]           host_wdata;
    logic                 host_gnt;
    logic [7:0]           host_rdata;
    logic                 host_rvalid;

    modport host (
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rdata, host_rvalid
    );

    modport arb (
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rdata, host_rvalid
    );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Shares one 256x8 synchronous single-port RAM between decoded SPI frames and a host port.
// SPI holds at most one pending access. Contests are round-robin, or host-first if HOST_FIXED_PRIO is set.
module spi_ram_arbiter #(
    parameter bit HOST_FIXED_PRIO = 1'b0,
    parameter int ADDR_SIZE       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    output logic                 spi_ovr,
    spi_ram_arbiter_if.arb       host,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata,
    output logic [1:0]           dbg_state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RDATA = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic                 pend_q, pend_d, pend_we_q, pend_we_d;
    logic [ADDR_SIZE-1:0] pend_addr_q, pend_addr_d;
    logic [7:0]           pend_wdata_q, pend_wdata_d;
    logic                 last_host_q, last_host_d, win_host_q, win_host_d;
    logic                 ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [ADDR_SIZE-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]           ram_wdata_q, ram_wdata_d;
    logic                 host_gnt_q, host_gnt_d, host_rvalid_q, host_rvalid_d;
    logic [7:0]           host_rdata_q, host_rdata_d, tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d, spi_ovr_q, spi_ovr_d;

    logic grant, pick_host, spi_grant, data_cmd, ovr;

    // Frame command bit 0 marks a data command (01 write, 11 read); bit 1 selects read vs write.
    assign data_cmd  = rx_valid && rx_data[ADDR_SIZE];
    assign grant     = (state_q == IDLE) && (pend_q || host.host_req);
    assign pick_host = host.host_req && (!pend_q || HOST_FIXED_PRIO || !last_host_q);
    assign spi_grant = grant && !pick_host;
    assign ovr       = data_cmd && pend_q && !spi_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = ACCESS;
            ACCESS:  state_d = ram_we_q ? IDLE : RDATA;
            RDATA:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        pend_d        = pend_q;
        pend_we_d     = pend_we_q;
        pend_addr_d   = pend_addr_q;
        pend_wdata_d  = pend_wdata_q;
        last_host_d   = last_host_q;
        win_host_d    = win_host_q;
        ram_en_d      = 1'b0;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        host_gnt_d    = 1'b0;
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = 1'b0;
        tx_data_d     = tx_data_q;
        tx_valid_d    = 1'b0;
        spi_ovr_d     = ovr;

        if (rx_valid && !rx_data[ADDR_SIZE]) begin
            if (rx_data[ADDR_SIZE+1]) rd_addr_d = rx_data[ADDR_SIZE-1:0];
            else                      wr_addr_d = rx_data[ADDR_SIZE-1:0];
        end

        // Clear on grant first so a data command arriving on the same edge re-arms the entry.
        if (spi_grant) pend_d = 1'b0;
        if (data_cmd && !ovr) begin
            pend_d    = 1'b1;
            pend_we_d = !rx_data[ADDR_SIZE+1];
            if (rx_data[ADDR_SIZE+1]) begin
                pend_addr_d = rd_addr_q;
            end else begin
                pend_addr_d  = wr_addr_q;
                pend_wdata_d = rx_data[7:0];
            end
        end

        if (grant) begin
            ram_en_d    = 1'b1;
            last_host_d = pick_host;
            win_host_d  = pick_host;
            host_gnt_d  = pick_host;
            if (pick_host) begin
                ram_we_d    = host.host_we;
                ram_addr_d  = host.host_addr;
                ram_wdata_d = host.host_wdata;
            end else begin
                ram_we_d    = pend_we_q;
                ram_addr_d  = pend_addr_q;
                ram_wdata_d = pend_wdata_q;
            end
        end

        if (state_q == RDATA) begin
            if (win_host_q) begin
                host_rdata_d  = ram_rdata;
                host_rvalid_d = 1'b1;
            end else begin
                tx_data_d  = ram_rdata;
                tx_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            pend_q        <= 1'b0;
            pend_we_q     <= 1'b0;
            pend_addr_q   <= '0;
            pend_wdata_q  <= '0;
            last_host_q   <= 1'b1;
            win_host_q    <= 1'b0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            host_gnt_q    <= 1'b0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            spi_ovr_q     <= 1'b0;
        end else begin
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            pend_q        <= pend_d;
            pend_we_q     <= pend_we_d;
            pend_addr_q   <= pend_addr_d;
            pend_wdata_q  <= pend_wdata_d;
            last_host_q   <= last_host_d;
            win_host_q    <= win_host_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            host_gnt_q    <= host_gnt_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            spi_ovr_q     <= spi_ovr_d;
        end
    end

    assign tx_data          = tx_data_q;
    assign tx_valid         = tx_valid_q;
    assign spi_ovr          = spi_ovr_q;
    assign host.host_gnt    = host_gnt_q;
    assign host.host_rdata  = host_rdata_q;
    assign host.host_rvalid = host_rvalid_q;
    assign ram_en           = ram_en_q;
    assign ram_we           = ram_we_q;
    assign ram_addr         = ram_addr_q;
    assign ram_wdata        = ram_wdata_q;
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: RAM model, event logs with cycle stamps, hand-computed expectations.
// A second instance with HOST_FIXED_PRIO=1 is used only for the fixed-priority contest.
module tb_spi_ram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [9:0] rx_data, rx_data2;
    logic       rx_valid, rx_valid2;
    logic [7:0] tx_data, tx_data2;
    logic       tx_valid, tx_valid2, spi_ovr, spi_ovr2;
    logic       ram_en, ram_we, ram_en2, ram_we2;
    logic [7:0] ram_addr, ram_wdata, ram_rdata, ram_addr2, ram_wdata2, ram_rdata2;
    logic [1:0] dbg_state, dbg_state2;

    spi_ram_arbiter_if hif ();
    spi_ram_arbiter_if hif2 ();

    spi_ram_arbiter #(.HOST_FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .spi_ovr(spi_ovr), .host(hif.arb),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .dbg_state_o(dbg_state)
    );

    spi_ram_arbiter #(.HOST_FIXED_PRIO(1'b1)) dut_fix (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data2), .rx_valid(rx_valid2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .spi_ovr(spi_ovr2), .host(hif2.arb),
        .ram_en(ram_en2), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
        .ram_rdata(ram_rdata2), .dbg_state_o(dbg_state2)
    );
    assign ram_rdata2 = 8'h5A;

    // 256x8 synchronous RAM: read data appears the cycle after the strobe.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard for SPI read data plus event logs stamped with the cycle number.
    logic [7:0]  exp_q[$];
    int          tx_cyc_q[$];
    int          hr_cyc_q[$];
    int          gnt_cyc_q[$];
    logic [17:0] acc_q[$];
    logic        gnt2_q[$];
    int          ovr_cnt = 0;

    always @(negedge clk) begin
        if (tx_valid) begin
            tx_cyc_q.push_back(cyc);
            if (exp_q.size() > 0) check("tx_data", tx_data, exp_q.pop_front());
            else                  check("tx_unexpected", exp_q.size(), 1);
        end
        if (hif.host_rvalid) hr_cyc_q.push_back(cyc);
        if (hif.host_gnt)    gnt_cyc_q.push_back(cyc);
        if (spi_ovr)         ovr_cnt++;
        if (ram_en)          acc_q.push_back({hif.host_gnt, ram_we, ram_addr, ram_wdata});
        if (ram_en2)         gnt2_q.push_back(hif2.host_gnt);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        tx_cyc_q.delete();
        hr_cyc_q.delete();
        gnt_cyc_q.delete();
        acc_q.delete();
        gnt2_q.delete();
        ovr_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic send(input logic [9:0] f);
        rx_data  = f;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send2(input logic [9:0] f);
        rx_data2  = f;
        rx_valid2 = 1'b1;
        tick(1);
        rx_valid2 = 1'b0;
    endtask

    task automatic host_issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        hif.host_we    = we;
        hif.host_addr  = addr;
        hif.host_wdata = wdata;
        hif.host_req   = 1'b1;
    endtask

    // Returns in the cycle the grant is visible and drops the request there.
    task automatic wait_gnt(input bit second, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (second ? hif2.host_gnt : hif.host_gnt) begin
                got = 1'b1;
                break;
            end
            tick(1);
        end
        check(tag, got, 1);
        if (second) hif2.host_req = 1'b0;
        else        hif.host_req  = 1'b0;
    endtask

    int t;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h3C;
        rst_n = 1'b0;
        rx_data = '0;  rx_valid = 1'b0;
        rx_data2 = '0; rx_valid2 = 1'b0;
        hif.host_req = 1'b0;  hif.host_we = 1'b0;  hif.host_addr = '0;  hif.host_wdata = '0;
        hif2.host_req = 1'b0; hif2.host_we = 1'b0; hif2.host_addr = '0; hif2.host_wdata = '0;

        // Reset state
        tick(2);
        check("rst_state", dbg_state, 0);
        check("rst_outs", {tx_valid, spi_ovr, ram_en, ram_we, hif.host_gnt, hif.host_rvalid}, 0);
        check("rst_data", {tx_data, ram_addr, ram_wdata, hif.host_rdata}, 0);
        rst_n = 1'b1;
        tick(1);
        check("idle_after_rst", dbg_state, 0);

        // SPI write then read back through tx
        clear_logs();
        exp_q.push_back(8'hA7);
        send(10'h005);
        send(10'h1A7);
        send(10'h205);
        t = cyc;
        send(10'h300);
        tick(8);
        check("spi_wr_acc", (acc_q.size() > 0) ? acc_q[0] : 18'h3FFFF, {1'b0, 1'b1, 8'h05, 8'hA7});
        check("spi_mem5", mem[5], 8'hA7);
        check("spi_rd_acc", (acc_q.size() > 1) ? acc_q[1][17:8] : 10'h3FF, {1'b0, 1'b0, 8'h05});
        check("tx_count", tx_cyc_q.size(), 1);
        check("tx_latency", (tx_cyc_q.size() > 0) ? tx_cyc_q[0] : -1, t + 4);
        check("tx_hold", tx_data, 8'hA7);

        // Host read
        clear_logs();
        t = cyc;
        host_issue(1'b0, 8'h10, 8'h00);
        tick(1);
        hif.host_req = 1'b0;
        tick(5);
        check("host_gnt_cyc", (gnt_cyc_q.size() > 0) ? gnt_cyc_q[0] : -1, t + 1);
        check("host_rv_cyc", (hr_cyc_q.size() > 0) ? hr_cyc_q[0] : -1, t + 3);
        check("host_rdata", hif.host_rdata, 8'h3C);
        check("host_no_tx", tx_cyc_q.size(), 0);

        // Contest after reset: SPI first, then host
        do_reset();
        clear_logs();
        exp_q.push_back(8'h3C);
        send(10'h210);
        send(10'h300);
        host_issue(1'b0, 8'h10, 8'h00);
        wait_gnt(1'b0, "c1_gnt_seen");
        tick(4);
        check("c1_count", acc_q.size(), 2);
        check("c1_first_spi", (acc_q.size() > 0) ? acc_q[0][17] : 1'bx, 1'b0);
        check("c1_second_host", (acc_q.size() > 1) ? acc_q[1][17] : 1'bx, 1'b1);
        // SPI-only write leaves SPI as last winner, so the next contest goes to host
        send(10'h040);
        send(10'h177);
        tick(4);
        check("mem40", mem[8'h40], 8'h77);
        clear_logs();
        exp_q.push_back(8'h3C);
        send(10'h300);
        host_issue(1'b0, 8'h10, 8'h00);
        wait_gnt(1'b0, "c2_gnt_seen");
        tick(5);
        check("c2_first_host", (acc_q.size() > 0) ? acc_q[0][17] : 1'bx, 1'b1);
        check("c2_second_spi", (acc_q.size() > 1) ? acc_q[1][17] : 1'bx, 1'b0);
        check("c2_host_rdata", hif.host_rdata, 8'h3C);

        // Fixed host priority: host first in both contests
        clear_logs();
        for (int k = 0; k < 2; k++) begin
            send2(10'h300);
            hif2.host_req = 1'b1;
            wait_gnt(1'b1, "fix_gnt_seen");
            tick(5);
        end
        check("fix_count", gnt2_q.size(), 4);
        check("fix_order", (gnt2_q.size() == 4) ? {gnt2_q[0], gnt2_q[1], gnt2_q[2], gnt2_q[3]} : 4'hF, 4'b1010);

        // Overrun: two data frames while host holds the RAM
        clear_logs();
        send(10'h030);
        host_issue(1'b0, 8'h10, 8'h00);
        tick(1);
        hif.host_req = 1'b0;
        send(10'h1C4);
        send(10'h1EE);
        check("ovr_pulse", spi_ovr, 1'b1);
        tick(1);
        check("ovr_one_cycle", spi_ovr, 1'b0);
        tick(5);
        check("ovr_count", ovr_cnt, 1);
        check("ovr_acc_count", acc_q.size(), 2);
        check("ovr_first_kept", (acc_q.size() > 1) ? acc_q[1] : 18'h3FFFF, {1'b0, 1'b1, 8'h30, 8'hC4});
        check("ovr_mem30", mem[8'h30], 8'hC4);

        // Address isolation: pending write keeps its own address
        clear_logs();
        send(10'h003);
        host_issue(1'b0, 8'h10, 8'h00);
        tick(1);
        hif.host_req = 1'b0;
        send(10'h111);
        send(10'h009);
        tick(4);
        send(10'h122);
        tick(4);
        check("iso_mem3", mem[3], 8'h11);
        check("iso_mem9", mem[9], 8'h22);
        check("iso_acc", (acc_q.size() > 2) ? acc_q[2] : 18'h3FFFF, {1'b0, 1'b1, 8'h09, 8'h22});

        // Reset during RDATA
        clear_logs();
        send(10'h203);
        send(10'h300);
        tick(2);
        check("mid_state_rdata", dbg_state, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {tx_valid, spi_ovr, ram_en, ram_we, hif.host_gnt, hif.host_rvalid}, 0);
        check("mid_rst_data", {tx_data, ram_addr, ram_wdata, hif.host_rdata}, 0);
        check("mid_rst_state", dbg_state, 0);
        tick(2);
        rst_n = 1'b1;
        tick(8);
        check("mid_no_tx", tx_cyc_q.size(), 0);
        check("mid_no_rvalid", hr_cyc_q.size(), 0);
        check("mid_idle", dbg_state, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
